// File: rtl/level_judge_if.sv
// Level-end strobe from the play logic plus judge results toward the level counter,
// display and sound logic.
interface level_judge_if #(
    parameter int unsigned DIFF_W  = 5,
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned LIVES   = 3
);
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);

    logic                 levelComplete;
    logic [DIFF_W-1:0]    difference;
    logic                 incLevel;
    logic                 loseLife;
    logic                 lose;
    logic                 win;
    logic [LEVEL_W-1:0]   level;
    logic [LIVES_W-1:0]   livesLeft;
    logic [DIFF_W-1:0]    tolerance;

    modport master (
        output levelComplete, difference,
        input  incLevel, loseLife, lose, win, level, livesLeft, tolerance
    );

    modport slave (
        input  levelComplete, difference,
        output incLevel, loseLife, lose, win, level, livesLeft, tolerance
    );
endinterface

// File: rtl/level_judge.sv
// End-of-level judge: compares difference to a level-dependent tolerance, advances
// the level or spends a life, and latches game-over / game-won.
module level_judge #(
    parameter int unsigned DIFF_W    = 5,
    parameter int unsigned LEVEL_W   = 4,
    parameter int unsigned MAX_LEVEL = 10,
    parameter int unsigned BASE_TOL  = 2,
    parameter int unsigned TOL_STEP  = 4,
    parameter int unsigned LIVES     = 3
) (
    input  logic          Clk100M,
    input  logic          Reset,
    level_judge_if.slave  bus
);
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_OVER = 2'd1;
    localparam logic [1:0] ST_WON  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                prev_q;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic                inc_q, inc_d;
    logic                loss_q, loss_d;
    logic                lose_q, lose_d;
    logic                win_q, win_d;
    logic [31:0]         drop_c;
    logic [DIFF_W-1:0]   tol_c;
    logic                judge_c;

    // Tolerance is a pure function of the level register, saturating at zero.
    assign drop_c  = 32'(level_q) / 32'(TOL_STEP);
    assign tol_c   = (drop_c >= 32'(BASE_TOL)) ? '0 : DIFF_W'(32'(BASE_TOL) - drop_c);
    assign judge_c = bus.levelComplete & ~prev_q;

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state_q <= ST_PLAY;
            prev_q  <= 1'b1;
            level_q <= '0;
            lives_q <= LIVES_W'(LIVES);
            inc_q   <= 1'b0;
            loss_q  <= 1'b0;
            lose_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= bus.levelComplete;
            level_q <= level_d;
            lives_q <= lives_d;
            inc_q   <= inc_d;
            loss_q  <= loss_d;
            lose_q  <= lose_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        inc_d   = 1'b0;
        loss_d  = 1'b0;
        lose_d  = lose_q;
        win_d   = win_q;
        case (state_q)
            ST_PLAY: begin
                if (judge_c) begin
                    if (bus.difference <= tol_c) begin
                        inc_d   = 1'b1;
                        level_d = level_q + LEVEL_W'(1);
                        if (level_d == LEVEL_W'(MAX_LEVEL)) begin
                            state_d = ST_WON;
                            win_d   = 1'b1;
                        end
                    end else begin
                        loss_d  = 1'b1;
                        lives_d = lives_q - LIVES_W'(1);
                        if (lives_q == LIVES_W'(1)) begin
                            state_d = ST_OVER;
                            lose_d  = 1'b1;
                        end
                    end
                end
            end
            ST_OVER, ST_WON: ;
            default: state_d = ST_PLAY;
        endcase
    end

    assign bus.incLevel  = inc_q;
    assign bus.loseLife  = loss_q;
    assign bus.lose      = lose_q;
    assign bus.win       = win_q;
    assign bus.level     = level_q;
    assign bus.livesLeft = lives_q;
    assign bus.tolerance = tol_c;
endmodule

// File: tb/tb_level_judge.sv
// Directed bench for level_judge: game-rule model checked every cycle plus literal
// expectations for each scenario.
module tb_level_judge;
    localparam int DIFF_W    = 5;
    localparam int LEVEL_W   = 4;
    localparam int MAX_LEVEL = 10;
    localparam int BASE_TOL  = 2;
    localparam int TOL_STEP  = 4;
    localparam int LIVES     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    level_judge_if #(.DIFF_W(DIFF_W), .LEVEL_W(LEVEL_W), .LIVES(LIVES)) bus ();

    level_judge #(
        .DIFF_W(DIFF_W), .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL),
        .BASE_TOL(BASE_TOL), .TOL_STEP(TOL_STEP), .LIVES(LIVES)
    ) dut (
        .Clk100M(clk),
        .Reset(rst),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;
    int inc_cnt = 0;
    int loss_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tol_of(input int lvl);
        int t;
        t = BASE_TOL - lvl / TOL_STEP;
        return (t < 0) ? 0 : t;
    endfunction

    // Game-rule model: what the outputs must be after each clock edge.
    int m_level = 0, m_lives = LIVES;
    bit m_inc = 0, m_loss = 0, m_lose = 0, m_win = 0, m_prev = 1;

    always @(posedge clk) begin
        int nl, nv;
        bit ni, nf, nlo, nw, edge_seen;
        nl = m_level; nv = m_lives; ni = 0; nf = 0; nlo = m_lose; nw = m_win;
        if (rst) begin
            nl = 0; nv = LIVES; nlo = 0; nw = 0;
            m_prev <= 1'b1;
        end else begin
            edge_seen = bus.levelComplete && !m_prev;
            if (edge_seen && !m_lose && !m_win) begin
                if (int'(bus.difference) <= tol_of(m_level)) begin
                    ni = 1; nl = m_level + 1;
                    if (nl == MAX_LEVEL) nw = 1;
                end else begin
                    nf = 1; nv = m_lives - 1;
                    if (nv == 0) nlo = 1;
                end
            end
            m_prev <= bus.levelComplete;
        end
        m_level <= nl; m_lives <= nv; m_inc <= ni; m_loss <= nf;
        m_lose <= nlo; m_win <= nw;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("incLevel",  int'(bus.incLevel),  int'(m_inc));
            chk("loseLife",  int'(bus.loseLife),  int'(m_loss));
            chk("lose",      int'(bus.lose),      int'(m_lose));
            chk("win",       int'(bus.win),       int'(m_win));
            chk("level",     int'(bus.level),     m_level);
            chk("livesLeft", int'(bus.livesLeft), m_lives);
            chk("tolerance", int'(bus.tolerance), tol_of(m_level));
            if (bus.incLevel === 1'b1) inc_cnt++;
            if (bus.loseLife === 1'b1) loss_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.levelComplete = 1'b0;
        rst = 1'b1;
        cyc(1);
        check_en = 1'b1;
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic strobe(input int d);
        bus.levelComplete = 1'b1;
        bus.difference = DIFF_W'(d);
        cyc(1);
        bus.levelComplete = 1'b0;
        cyc(2);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_inc"},   int'(bus.incLevel),  0);
        chk({tag, "_loss"},  int'(bus.loseLife),  0);
        chk({tag, "_lose"},  int'(bus.lose),      0);
        chk({tag, "_win"},   int'(bus.win),       0);
        chk({tag, "_level"}, int'(bus.level),     0);
        chk({tag, "_lives"}, int'(bus.livesLeft), 3);
        chk({tag, "_tol"},   int'(bus.tolerance), 2);
    endtask

    initial begin
        int i0, l0;
        bus.levelComplete = 1'b0;
        bus.difference = '0;
        cyc(2);

        // 1: single pass at the tolerance boundary
        do_reset();
        check_reset_values("s1_rst");
        i0 = inc_cnt;
        strobe(2);
        chk("s1_pulses", inc_cnt - i0, 1);
        chk("s1_level", int'(bus.level), 1);
        chk("s1_model_level", m_level, 1);
        chk("s1_lives", int'(bus.livesLeft), 3);
        chk("s1_tol", int'(bus.tolerance), 2);

        // 2: three misses end the game; a fourth is ignored
        do_reset();
        l0 = loss_cnt;
        strobe(3);
        chk("s2_lives1", int'(bus.livesLeft), 2);
        strobe(3);
        chk("s2_lives2", int'(bus.livesLeft), 1);
        strobe(3);
        chk("s2_lives3", int'(bus.livesLeft), 0);
        chk("s2_lose", int'(bus.lose), 1);
        chk("s2_level", int'(bus.level), 0);
        chk("s2_pulses", loss_cnt - l0, 3);
        i0 = inc_cnt;
        strobe(3);
        chk("s2_ignored_loss", loss_cnt - l0, 3);
        chk("s2_ignored_inc", inc_cnt - i0, 0);
        chk("s2_frozen_lives", int'(bus.livesLeft), 0);

        // 3: held strobe gives exactly one judgement (reset also leaves OVER)
        do_reset();
        chk("s3_rst_lose", int'(bus.lose), 0);
        i0 = inc_cnt;
        bus.levelComplete = 1'b1;
        bus.difference = '0;
        cyc(5);
        bus.levelComplete = 1'b0;
        cyc(2);
        chk("s3_pulses", inc_cnt - i0, 1);
        chk("s3_level", int'(bus.level), 1);

        // 4: tolerance drops at level 4
        do_reset();
        repeat (4) strobe(0);
        chk("s4_level", int'(bus.level), 4);
        chk("s4_tol", int'(bus.tolerance), 1);
        chk("s4_model_tol", tol_of(m_level), 1);
        l0 = loss_cnt;
        strobe(2);
        chk("s4_loss", loss_cnt - l0, 1);
        chk("s4_lives", int'(bus.livesLeft), 2);
        chk("s4_level_kept", int'(bus.level), 4);

        // 5: clearing level 9 wins; further strobes are ignored
        do_reset();
        i0 = inc_cnt;
        repeat (10) strobe(0);
        chk("s5_pulses", inc_cnt - i0, 10);
        chk("s5_level", int'(bus.level), 10);
        chk("s5_win", int'(bus.win), 1);
        chk("s5_lose", int'(bus.lose), 0);
        chk("s5_tol", int'(bus.tolerance), 0);
        strobe(0);
        chk("s5_ignored", inc_cnt - i0, 10);
        chk("s5_frozen", int'(bus.level), 10);

        // 6: reset beats a coincident rising strobe, then held strobe is not judged
        do_reset();
        repeat (3) strobe(0);
        strobe(3);
        chk("s6_pre_level", int'(bus.level), 3);
        chk("s6_pre_lives", int'(bus.livesLeft), 2);
        i0 = inc_cnt; l0 = loss_cnt;
        bus.levelComplete = 1'b1;
        bus.difference = DIFF_W'(0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_reset_values("s6_rst");
        cyc(3);
        chk("s6_held_inc", inc_cnt - i0, 0);
        chk("s6_held_loss", loss_cnt - l0, 0);
        chk("s6_held_level", int'(bus.level), 0);
        bus.levelComplete = 1'b0;
        cyc(1);
        strobe(1);
        chk("s6_inc", inc_cnt - i0, 1);
        chk("s6_level", int'(bus.level), 1);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
